// File: rtl/seq_delay_pkg.sv
// Shared constants and helpers for the seq_delay_line strobe delay line.
package seq_delay_pkg;

  localparam int CH_DEF            = 5;
  localparam int MAX_DELAY_DEF     = 16;
  localparam int DEFAULT_DELAY_DEF = 10;
  localparam int CFG_CH_W          = 4;

  // Width of a delay field able to hold 0..max_delay inclusive.
  function automatic int dw_of(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/seq_delay_line_if.sv
// Runtime delay-configuration port of seq_delay_line.
// There is no valid/ready handshake: cfg_we is a single-cycle write strobe that is
// always accepted; cfg_err answers one cycle later when the write was rejected.
interface seq_delay_line_if
  import seq_delay_pkg::*;
#(
  parameter int DW = dw_of(MAX_DELAY_DEF)
);
  logic                cfg_we;
  logic [CFG_CH_W-1:0] cfg_ch;
  logic [DW-1:0]       cfg_delay;
  logic                cfg_err;

  modport master (output cfg_we, output cfg_ch, output cfg_delay, input  cfg_err);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_delay, output cfg_err);
endinterface

// File: rtl/seq_delay_chan.sv
// One strobe channel: shift register, programmable delay register and tap/bypass mux.
module seq_delay_chan #(
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 10,
  parameter int DW            = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          seq_in,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          seq_out
);

  logic [MAX_DELAY-1:0] sr;
  logic [DW-1:0]        d;
  logic                 tap;

  // A clear drops the whole history including this cycle's input bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      d  <= DW'(DEFAULT_DELAY);
    end else begin
      if (clr) begin
        sr <= '0;
      end else begin
        sr <= (sr << 1) | MAX_DELAY'(seq_in);
      end
      if (load) begin
        d <= load_val;
      end
    end
  end

  // Stage i holds the input sampled i+1 edges ago, so delay d reads stage d-1.
  always_comb begin
    tap = 1'b0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (d == DW'(i + 1)) begin
        tap = sr[i];
      end
    end
  end

  assign seq_out = (d == '0) ? seq_in : tap;

endmodule

// File: rtl/seq_delay_line.sv
// Per-channel programmable strobe delay line with write decode and error flags.
// Optional overlap checker enabled by defining SEQ_DELAY_OVERLAP_CHK_EN.
module seq_delay_line
  import seq_delay_pkg::*;
#(
  parameter int CH            = CH_DEF,
  parameter int MAX_DELAY     = MAX_DELAY_DEF,
  parameter int DEFAULT_DELAY = DEFAULT_DELAY_DEF,
  localparam int DW           = dw_of(MAX_DELAY)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH-1:0]        seq_in,
  output logic [CH-1:0]        seq_out,
  input  logic                 flush,
  seq_delay_line_if.slave      cfg,
  output logic                 overlap_err
);

  logic          ch_ok;
  logic          dly_ok;
  logic          wr_ok;
  logic [CH-1:0] ch_load;
  logic          cfg_err_q;

  assign ch_ok  = {1'b0, cfg.cfg_ch} < (CFG_CH_W + 1)'(CH);
  assign dly_ok = cfg.cfg_delay <= DW'(MAX_DELAY);
  assign wr_ok  = cfg.cfg_we && ch_ok && dly_ok;

  always_comb begin
    ch_load = '0;
    for (int c = 0; c < CH; c++) begin
      ch_load[c] = wr_ok && (cfg.cfg_ch == CFG_CH_W'(c));
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    seq_delay_chan #(
      .MAX_DELAY     (MAX_DELAY),
      .DEFAULT_DELAY (DEFAULT_DELAY),
      .DW            (DW)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .seq_in   (seq_in[c]),
      .clr      (flush || ch_load[c]),
      .load     (ch_load[c]),
      .load_val (cfg.cfg_delay),
      .seq_out  (seq_out[c])
    );
  end

  // A rejected write leaves every channel untouched and only raises the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg.cfg_we && !wr_ok;
    end
  end

  assign cfg.cfg_err = cfg_err_q;

`ifdef SEQ_DELAY_OVERLAP_CHK_EN
  logic multi_hot;
  logic overlap_q;

  // Clearing the lowest set bit leaves something only when two or more are high.
  assign multi_hot = (seq_out & (seq_out - 1'b1)) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overlap_q <= 1'b0;
    end else if (flush) begin
      overlap_q <= 1'b0;
    end else if (multi_hot) begin
      overlap_q <= 1'b1;
    end
  end

  assign overlap_err = overlap_q;
`else
  assign overlap_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_delay_line.sv
// Directed plus randomized bench for seq_delay_line against a cycle-indexed input-history model.
module tb_seq_delay_line;
  import seq_delay_pkg::*;

  localparam int CH        = CH_DEF;
  localparam int MAX_DELAY = MAX_DELAY_DEF;
  localparam int DEF_D     = DEFAULT_DELAY_DEF;
  localparam int DW        = dw_of(MAX_DELAY);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [CH-1:0] seq_in;
  logic [CH-1:0] seq_out;
  logic          flush;
  logic          overlap_err;

  seq_delay_line_if #(.DW(DW)) cfg_bus ();

  seq_delay_line #(
    .CH            (CH),
    .MAX_DELAY     (MAX_DELAY),
    .DEFAULT_DELAY (DEF_D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seq_in      (seq_in),
    .seq_out     (seq_out),
    .flush       (flush),
    .cfg         (cfg_bus.slave),
    .overlap_err (overlap_err)
  );

  // reference model: full input log indexed by edge number
  logic [CH-1:0] in_log [0:8191];
  int            n_edge;
  int            d_m      [CH];
  int            last_clr [CH];
  logic          err_m;
  logic          ov_m;
  logic [CH-1:0] exp_out_now;

  int total = 0;
  int bad   = 0;

  function automatic logic [CH-1:0] model_out(input logic [CH-1:0] cur_in);
    logic [CH-1:0] r;
    int src;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      if (d_m[c] == 0) begin
        r[c] = cur_in[c];
      end else begin
        src = n_edge - d_m[c] + 1;
        if (src > last_clr[c]) r[c] = in_log[src][c];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      d_m[c]      = DEF_D;
      last_clr[c] = n_edge;
    end
    err_m = 1'b0;
    ov_m  = 1'b0;
  endtask

  task automatic model_edge();
    logic valid;
    n_edge++;
    in_log[n_edge] = seq_in;
    valid = cfg_bus.cfg_we && (int'(cfg_bus.cfg_ch) < CH) && (int'(cfg_bus.cfg_delay) <= MAX_DELAY);
    err_m = cfg_bus.cfg_we && !valid;
`ifdef SEQ_DELAY_OVERLAP_CHK_EN
    if (flush) ov_m = 1'b0;
    else if ($countones(exp_out_now) >= 2) ov_m = 1'b1;
`endif
    if (valid) begin
      d_m[cfg_bus.cfg_ch]      = int'(cfg_bus.cfg_delay);
      last_clr[cfg_bus.cfg_ch] = n_edge;
    end
    if (flush) begin
      for (int c = 0; c < CH; c++) last_clr[c] = n_edge;
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, n_edge, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    exp_out_now = model_out(seq_in);
    chk({tag, ":seq_out"}, 32'(seq_out), 32'(exp_out_now));
    chk({tag, ":cfg_err"}, 32'(cfg_bus.cfg_err), 32'(err_m));
    chk({tag, ":overlap_err"}, 32'(overlap_err), 32'(ov_m));
  endtask

  // driver tasks: called at posedge+1, check at posedge+4, return at next posedge+1
  task automatic step(input string tag, input logic [CH-1:0] in, input logic fl,
                      input logic we, input logic [3:0] ch, input logic [DW-1:0] dl);
    seq_in            = in;
    flush             = fl;
    cfg_bus.cfg_we    = we;
    cfg_bus.cfg_ch    = ch;
    cfg_bus.cfg_delay = dl;
    #3;
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, '0, 1'b0, 1'b0, 4'd0, '0);
  endtask

  task automatic write(input string tag, input logic [3:0] ch, input logic [DW-1:0] dl);
    step(tag, '0, 1'b0, 1'b1, ch, dl);
  endtask

  function automatic logic [CH-1:0] rand_bits();
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) r[c] = ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  initial begin
    rst_n             = 1'b0;
    seq_in            = '0;
    flush             = 1'b0;
    cfg_bus.cfg_we    = 1'b0;
    cfg_bus.cfg_ch    = '0;
    cfg_bus.cfg_delay = '0;
    exp_out_now       = '0;
    n_edge            = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // default delay: single pulse on ch0 emerges 10 edges later
    step("dflt_pulse", 5'b00001, 1'b0, 1'b0, 4'd0, '0);
    idle("dflt_wait", 12);

    // ch2 delay 3, 2-cycle pulse right after the write
    write("wr_ch2", 4'd2, 5'd3);
    step("ch2_pulse", 5'b00100, 1'b0, 1'b0, 4'd0, '0);
    step("ch2_pulse", 5'b00100, 1'b0, 1'b0, 4'd0, '0);
    idle("ch2_wait", 6);

    // ch1 bypass
    write("wr_ch1", 4'd1, 5'd0);
    for (int i = 0; i < 6; i++) step("ch1_bypass", rand_bits(), 1'b0, 1'b0, 4'd0, '0);

    // rejected writes, then confirm timing is unchanged
    write("bad_ch", 4'd7, 5'd2);
    write("bad_dly", 4'd0, 5'd17);
    write("bad_both", 4'd15, 5'd31);
    step("post_bad", 5'b00101, 1'b0, 1'b0, 4'd0, '0);
    idle("post_bad_wait", 11);

    // pulses in flight everywhere, then flush with a simultaneous ch4 write
    for (int i = 0; i < 4; i++) step("fill", 5'b11111, 1'b0, 1'b0, 4'd0, '0);
    step("flush_wr", 5'b11111, 1'b1, 1'b1, 4'd4, 5'd5);
    step("ch4_pulse", 5'b10000, 1'b0, 1'b0, 4'd0, '0);
    idle("flush_wait", 12);

    // flush combined with a rejected write
    step("flush_bad", 5'b00011, 1'b1, 1'b1, 4'd9, 5'd1);
    idle("flush_bad_wait", 2);

    // overlap scenario: ch0 and ch1 at delay 2, simultaneous pulses
    write("ov_wr0", 4'd0, 5'd2);
    write("ov_wr1", 4'd1, 5'd2);
    step("ov_pulse", 5'b00011, 1'b0, 1'b0, 4'd0, '0);
    idle("ov_hold", 5);
    step("ov_flush", '0, 1'b1, 1'b0, 4'd0, '0);
    idle("ov_clr", 3);

    // max delay boundary on ch3
    write("max_wr", 4'd3, 5'd16);
    step("max_pulse", 5'b01000, 1'b0, 1'b0, 4'd0, '0);
    idle("max_wait", 18);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic we;
      logic fl;
      we = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 29) == 0);
      step("rand", rand_bits(), fl, we, 4'($urandom_range(0, 7)), DW'($urandom_range(0, 20)));
    end

    // asynchronous reset in mid-operation
    seq_in = 5'b11111;
    rst_n  = 1'b0;
    model_reset();
    #2;
    check_outputs("mid_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("after_rst", 5'b00001, 1'b0, 1'b0, 4'd0, '0);
    idle("after_rst_wait", 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout edge=%0d", n_edge);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/seq_delay_line.md
# seq_delay_line

Clocked, parametrised delay line for processor control-sequence strobes. Each of `CH` channels delays its strobe by a programmable 0..`MAX_DELAY` clock cycles. Delays are set at runtime through a single-cycle write port, with flush, error reporting and optional overlap checking. It sits between the sequence-counter decode and the datapath enables, replacing fixed-length inverter-chain delays with deterministic cycle-accurate timing.

## Interface
- `CH`, 5: number of strobe channels (1..16).
- `MAX_DELAY`, 16: maximum per-channel delay in cycles (≥1).
- `DEFAULT_DELAY`, 10: per-channel delay loaded at reset (≤ `MAX_DELAY`).
- `DW`, `$clog2(MAX_DELAY+1)`: delay field width (derived; not overridden).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seq_in`  in  `CH`  strobe inputs, sampled each rising edge.
- `seq_out`  out  `CH`  delayed strobes.
- `flush`  in  1  clears all channel pipelines.
- `cfg_we`  in  1  delay write strobe.
- `cfg_ch`  in  4  channel index for the write.
- `cfg_delay`  in  `DW`  new delay value.
- `cfg_err`  out  1  one-cycle pulse on a rejected write.
- `overlap_err`  out  1  sticky flag; see Configuration.

## Operation
- Per channel: a `MAX_DELAY`-bit shift register, a `DW`-bit delay register `d`, and a tap mux.
- `d == 0`: `seq_out[c] = seq_in[c]`, a combinational bypass.
- `d ≥ 1`: `seq_out[c]` equals `seq_in[c]` sampled `d` edges earlier. It is taken from shift-register stage `d-1`, which is a registered output.
- Valid write: `cfg_we=1`, `cfg_ch < CH` and `cfg_delay ≤ MAX_DELAY`.
  - At the edge, `d[cfg_ch]` takes `cfg_delay`.
  - That channel's shift register clears to 0.
  - The `seq_in[cfg_ch]` bit of that cycle is discarded.
  - Other channels are unaffected.
- Invalid write: `cfg_ch ≥ CH` or `cfg_delay > MAX_DELAY`.
  - No state change.
  - `cfg_err` is high for exactly the next cycle.
- `flush=1`: at the edge, every shift register clears to 0 and that cycle's inputs are discarded. Delay registers are kept.
- Simultaneous flush and valid write: both apply; the result is identical to a flush plus the new `d`.
- Simultaneous flush and invalid write: the flush applies and `cfg_err` pulses.
- Reset:
  - Asserted mid-operation, it immediately clears all shift registers, `cfg_err` and `overlap_err`.
  - All `d` take `DEFAULT_DELAY`.
  - `seq_out` becomes 0, except channels with `DEFAULT_DELAY == 0`, which follow `seq_in`.

## Timing
- Latency is exactly `d` cycles per channel; there is no extra pipeline stage.
- A pulse of width `w` at the input emerges with width `w`.
- After a delay change, the first valid output appears `new_d` cycles after the first post-write input edge. The output is 0 until then.
- `cfg_err` and `overlap_err` are registered: asserted one edge after the causing event.
- There is no handshake; a write is accepted every cycle.

## Configuration
- `SEQ_DELAY_OVERLAP_CHK_EN` defined:
  - Each cycle in which two or more `seq_out` bits are high, `overlap_err` sets at the next edge.
  - It stays set until reset or `flush`.
- Undefined: `overlap_err` is tied to 0 and no checker logic exists. The port is present in both builds.

## Structure
- Package `seq_delay_pkg`: `CH` and `MAX_DELAY` defaults, the `DW` width helper function, and the `cfg_ch` width constant.
- Sub-module `seq_delay_chan`: one channel, holding the shift register, delay register, tap/bypass mux, and clear logic. It is instantiated `CH` times via generate.
- The top level holds write decode, error generation and the overlap checker.

## Test plan
- Reset with defaults; 1-cycle pulse on `seq_in[0]` at cycle 0 → `seq_out[0]` high at cycle 10 only; other outputs 0.
- Write ch2 `d=3`, then a 2-cycle pulse on `seq_in[2]` → `seq_out[2]` high for cycles +3 and +4 after the pulse start; ch2 output 0 during the first 3 cycles after the write.
- Write ch1 `d=0` → `seq_out[1]` mirrors `seq_in[1]` in the same cycle.
- Write `cfg_ch=7` or `cfg_delay=17` → `cfg_err` high for one cycle; all delays unchanged; pulse timing as before.
- Pulses in flight on all channels, then `flush` plus a valid write to ch4 `d=5` → all outputs 0 afterwards; ch4 then delays by 5.
- `SEQ_DELAY_OVERLAP_CHK_EN` build: ch0 and ch1 both at `d=2`, simultaneous input pulses → `overlap_err` set 3 cycles after the input and held; cleared by `flush`. Without the macro it stays 0.
